// File: rtl/mem_arb_pkg.sv
// Shared types and width helpers for the single-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Wide enough for MEM_LAT and STARVE_MAX up to 15
  localparam int LAT_W    = 4;
  localparam int STARVE_W = 4;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/mem_arb_lat_timer.sv
// Loadable down-counter tracking the in-flight memory access latency.
module mem_arb_lat_timer
  import mem_arb_pkg::*;
#(
  parameter int unsigned LOAD_VAL = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic busy,
  output logic done
);

  logic [LAT_W-1:0] cnt_r;

  // Count down from LOAD_VAL; done marks the response cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {LAT_W{1'b0}};
    end else if (load) begin
      cnt_r <= LAT_W'(LOAD_VAL);
    end else if (cnt_r != {LAT_W{1'b0}}) begin
      cnt_r <= cnt_r - LAT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign busy = (cnt_r != {LAT_W{1'b0}});
  assign done = (cnt_r == LAT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store requesters onto one fixed-latency memory port,
// routing each response back to the requester that issued it.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     if_req,
  input  logic [ADDR_W-1:0]        if_addr,
  output logic                     if_gnt,
  output logic                     if_rvalid,
  output logic [DATA_W-1:0]        if_rdata,
  input  logic                     d_req,
  input  logic                     d_we,
  input  logic [be_width(DATA_W)-1:0] d_be,
  input  logic [ADDR_W-1:0]        d_addr,
  input  logic [DATA_W-1:0]        d_wdata,
  output logic                     d_gnt,
  output logic                     d_rvalid,
  output logic [DATA_W-1:0]        d_rdata,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [be_width(DATA_W)-1:0] mem_be,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int BE_W = be_width(DATA_W);

  state_e              state_r;
  owner_e              owner_r;
  logic [STARVE_W-1:0] starve_r;
  logic                busy_s;
  logic                done_s;
  logic                free_s;
  logic                win_if_s;
  logic                win_d_s;
  logic                resp_s;

  mem_arb_lat_timer #(
    .LOAD_VAL (MEM_LAT)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (win_if_s | win_d_s),
    .busy  (busy_s),
    .done  (done_s)
  );

  // Pick a winner when the port is free; fetch overrides data once starved
  always_comb begin
    free_s   = ((state_r == IDLE) && !busy_s) || done_s;
    win_if_s = 1'b0;
    win_d_s  = 1'b0;
    if (reset || !free_s) begin
      win_if_s = 1'b0;
      win_d_s  = 1'b0;
    end else if (if_req && d_req) begin
      if (starve_r == STARVE_W'(STARVE_MAX)) begin
        win_if_s = 1'b1;
      end else begin
        win_d_s = 1'b1;
      end
    end else begin
      win_if_s = if_req;
      win_d_s  = d_req;
    end
  end

  // Drive the memory port from the winner; bus is zero when nothing issues
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = {BE_W{1'b0}};
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    if (win_d_s) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_be    = d_be;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (win_if_s) begin
      mem_en    = 1'b1;
      mem_be    = {BE_W{1'b1}};
      mem_addr  = if_addr;
    end else begin
      mem_en    = 1'b0;
    end
  end

  assign if_gnt    = win_if_s;
  assign d_gnt     = win_d_s;
  assign resp_s    = done_s && !reset && (state_r == BUSY);
  assign if_rvalid = resp_s && (owner_r == OWN_IF);
  assign d_rvalid  = resp_s && (owner_r == OWN_D);
  assign if_rdata  = if_rvalid ? mem_rdata : {DATA_W{1'b0}};
  assign d_rdata   = d_rvalid ? mem_rdata : {DATA_W{1'b0}};

  // Transaction ownership and starvation tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      owner_r  <= OWN_NONE;
      starve_r <= {STARVE_W{1'b0}};
    end else begin
      if (win_if_s || win_d_s) begin
        state_r <= BUSY;
        owner_r <= win_d_s ? OWN_D : OWN_IF;
      end else if (done_s) begin
        state_r <= IDLE;
        owner_r <= OWN_NONE;
      end else begin
        state_r <= state_r;
        owner_r <= owner_r;
      end
      if (win_if_s || !if_req) begin
        starve_r <= {STARVE_W{1'b0}};
      end else if (win_d_s && (starve_r != STARVE_W'(STARVE_MAX))) begin
        starve_r <= starve_r + STARVE_W'(1);
      end else begin
        starve_r <= starve_r;
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port memory arbiter for the multicycle RISC-V core: shares one fixed-latency memory between the instruction-fetch requester and the load/store requester. Sits between the core datapath and the unified instruction/data memory. Serialises accesses, issues one transaction at a time and routes each response back to its owner. Data accesses win by default; a starvation counter guarantees fetch progress.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- MEM_LAT, 2, cycles from mem_en to valid mem_rdata; legal range 1..15
- STARVE_MAX, 4, consecutive lost arbitrations after which fetch gets priority; legal range 1..15
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch data valid, one-cycle pulse
- if_rdata  out  DATA_W  fetch data
- d_req  in  1  data request; held with d_we/d_be/d_addr/d_wdata until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_be  in  DATA_W/8  byte enables (stores)
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid or store complete, one-cycle pulse
- d_rdata  out  DATA_W  load data; don't-care for stores
- mem_en  out  1  memory access issued this cycle
- mem_we  out  1  write strobe
- mem_be  out  DATA_W/8  byte enables
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid MEM_LAT cycles after mem_en

## Operation
- States: IDLE (no transaction in flight), BUSY (transaction in flight, latency counter running).
- Arbitration, evaluated only when free (IDLE, or BUSY in its final response cycle):
  - only one requester: it wins.
  - both requesting: d wins unless starve_cnt == STARVE_MAX, then if wins.
- Grant: winner's gnt = 1 combinationally in the issue cycle; mem_en = 1 and mem_* driven from the winner in the same cycle. Fetch: mem_we = 0, mem_be = all ones. Data: mem_we = d_we, mem_be = d_be, mem_wdata = d_wdata.
- Issue cycle T: owner registered, counter loaded with MEM_LAT, state -> BUSY.
- Response at T+MEM_LAT: owner's rvalid = 1, rdata = mem_rdata (combinational pass-through); non-owner rvalid = 0. Stores also pulse d_rvalid.
- Back-to-back: a new grant may issue in the response cycle; peak throughput is one access per MEM_LAT cycles.
- starve_cnt: +1 (saturating at STARVE_MAX) when both request and d wins; cleared when if is granted or if_req = 0.
- mem_we, mem_be, mem_addr, mem_wdata = 0 when mem_en = 0.

## Timing
- Reset: state IDLE, owner NONE, counter 0, starve_cnt 0. While reset = 1, all gnt, rvalid and mem_en = 0, regardless of inputs.
- Reset mid-transaction: in-flight response is dropped (no rvalid ever); first grant is possible in the first cycle after reset deasserts.
- Latency: gnt at T, rvalid at exactly T+MEM_LAT; MEM_LAT = 1 gives a grant every cycle.
- A requester deasserting req before gnt is legal; no grant is issued for it.
- if_gnt and d_gnt are never both 1; no gnt is issued while BUSY and not in the response cycle.

## Structure
- Package mem_arb_pkg: owner enum {OWN_NONE, OWN_IF, OWN_D}, state enum {IDLE, BUSY}, width helper constants.
- One sub-module, mem_arb_lat_timer: loadable down-counter giving the busy/done flags; arbiter, starvation counter and muxes stay in the top.

## Test plan
- Lone fetch, MEM_LAT=2: if_req with if_addr=0x100 at cycle 1 -> if_gnt, mem_en, mem_addr=0x100, mem_we=0, mem_be=0xF at 1; if_rvalid with mem_rdata value at 3.
- Store then load, back-to-back: d store 0x200/0xDEADBEEF/be=0x3 granted at 1 -> d_rvalid at 3, load 0x200 granted at 3 -> d_rvalid at 5; mem_* fields match each cycle.
- Contention, STARVE_MAX=4: if_req and d_req held continuously -> d wins 4 grants, then if wins the 5th, starve_cnt returns to 0; pattern repeats.
- Ownership routing: fetch granted at 1, data waiting -> at 3 if_rvalid=1, d_rvalid=0, d_gnt=1 in the same cycle; d_rvalid at 5 only.
- Reset mid-op: grant at 1, reset high at cycle 2 -> no rvalid at 3; all outputs 0 during reset; new grant in the first cycle after reset drops.
- MEM_LAT=1 streaming: d_req held for 6 cycles -> d_gnt and mem_en every cycle, d_rvalid every cycle from one cycle after the first grant.
